pwm_ctrl: RTL and testbench

PWM_CTRL -- requirements
Module: pwm_ctrl

---
 rtl/pwm_pkg.sv | 39 +++
 rtl/pwm_prescaler.sv | 26 ++
 rtl/pwm_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_pwm_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared register map, field positions and state type for the PWM controller.
package pwm_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PERIOD = 2'd1;
    localparam logic [1:0] ADDR_DUTY   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_FADE      = 1;
    localparam int CTRL_IE        = 2;
    localparam int CTRL_PRESC_LSB = 8;
    localparam int CTRL_STEP_LSB  = 16;

    localparam int STAT_DONE    = 0;
    localparam int STAT_PEND    = 1;
    localparam int STAT_DIR     = 2;
    localparam int STAT_CNT_LSB = 16;

    localparam int PRESC_W = 8;
    localparam int STEP_W  = 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } pwm_state_e;

    function automatic logic [31:0] pack_status(input logic done, input logic pend,
                                                input logic dir, input logic [15:0] cnt);
        logic [31:0] w;
        w = '0;
        w[STAT_DONE]            = done;
        w[STAT_PEND]            = pend;
        w[STAT_DIR]             = dir;
        w[STAT_CNT_LSB +: 16]   = cnt;
        return w;
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: one tick every PRESC+1 cycles, held at zero while cleared.
module pwm_prescaler
    import pwm_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_clr,
    input  logic [PRESC_W-1:0] i_presc,
    output logic               o_tick
);

    logic [PRESC_W-1:0] r_cnt;

    assign o_tick = !i_clr && (r_cnt == i_presc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr || o_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + PRESC_W'(1);
        end
    end

endmodule

// File: rtl/pwm_ctrl.sv
// Register-programmed PWM generator with shadowed period/duty, prescaler,
// optional duty fading and a level interrupt on period completion.
module pwm_ctrl
    import pwm_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  A,
    input  logic [31:0] WD,
    input  logic        WE,
    output logic [31:0] RD,
    output logic        PWM,
    output logic        IRQ
);

    pwm_state_e          r_state;
    pwm_state_e          w_state_next;
    logic                r_fade;
    logic                r_ie;
    logic [PRESC_W-1:0]  r_presc;
    logic [STEP_W-1:0]   r_step;
    logic [CW-1:0]       r_per_sh;
    logic [CW-1:0]       r_duty_sh;
    logic [CW-1:0]       r_per;
    logic [CW-1:0]       r_duty;
    logic [CW-1:0]       r_cnt;
    logic                r_done;
    logic                r_pend;
    logic                r_pend_duty;
    logic                r_dir;
    logic                r_pwm;

    logic                w_wr_ctrl;
    logic                w_wr_per;
    logic                w_wr_duty;
    logic                w_wr_stat;
    logic                w_run;
    logic                w_tick;
    logic                w_wrap;
    logic [CW:0]         w_fade_sum;
    logic [CW-1:0]       w_fade_duty;
    logic                w_fade_dir;
    logic [CW-1:0]       w_per_next;
    logic [CW-1:0]       w_duty_next;
    logic [CW-1:0]       w_cnt_next;
    logic                w_dir_next;
    logic                w_unused;

    assign w_wr_ctrl = WE && (A == ADDR_CTRL);
    assign w_wr_per  = WE && (A == ADDR_PERIOD);
    assign w_wr_duty = WE && (A == ADDR_DUTY);
    assign w_wr_stat = WE && (A == ADDR_STATUS);
    assign w_unused  = ^{WD[31:24], WD[7:3]};

    // The FSM state register doubles as CTRL.EN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_wr_ctrl) begin
            w_state_next = WD[CTRL_EN] ? S_RUN : S_IDLE;
        end
        // Counting only happens on edges that start and end in RUN.
        w_run = (r_state == S_RUN) && (w_state_next == S_RUN);
    end

    pwm_prescaler u_presc (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (!w_run),
        .i_presc (r_presc),
        .o_tick  (w_tick)
    );

    assign w_wrap = w_tick && (r_cnt == r_per);

    // Fade step saturates against the period being loaded at this wrap.
    always_comb begin
        w_fade_sum  = {1'b0, r_duty} + (CW+1)'(r_step);
        w_fade_duty = r_duty;
        w_fade_dir  = r_dir;
        if (!r_dir) begin
            if (w_fade_sum >= {1'b0, r_per_sh}) begin
                w_fade_duty = r_per_sh;
                w_fade_dir  = 1'b1;
            end else begin
                w_fade_duty = w_fade_sum[CW-1:0];
            end
        end else begin
            if (r_duty <= CW'(r_step)) begin
                w_fade_duty = '0;
                w_fade_dir  = 1'b0;
            end else begin
                w_fade_duty = r_duty - CW'(r_step);
            end
        end
    end

    always_comb begin
        w_per_next  = r_per;
        w_duty_next = r_duty;
        w_cnt_next  = r_cnt;
        w_dir_next  = r_dir;
        if (!w_run) begin
            w_per_next  = r_per_sh;
            w_duty_next = r_duty_sh;
            w_cnt_next  = '0;
        end else if (w_wrap) begin
            w_per_next = r_per_sh;
            w_cnt_next = '0;
            if (r_fade && !r_pend_duty) begin
                w_duty_next = w_fade_duty;
                w_dir_next  = w_fade_dir;
            end else begin
                w_duty_next = r_duty_sh;
            end
        end else if (w_tick) begin
            w_cnt_next = r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fade    <= 1'b0;
            r_ie      <= 1'b0;
            r_presc   <= '0;
            r_step    <= '0;
            r_per_sh  <= '0;
            r_duty_sh <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_fade  <= WD[CTRL_FADE];
                r_ie    <= WD[CTRL_IE];
                r_presc <= WD[CTRL_PRESC_LSB +: PRESC_W];
                r_step  <= WD[CTRL_STEP_LSB +: STEP_W];
            end
            if (w_wr_per) begin
                r_per_sh <= WD[CW-1:0];
            end
            if (w_wr_duty) begin
                r_duty_sh <= WD[CW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_per       <= '0;
            r_duty      <= '0;
            r_cnt       <= '0;
            r_dir       <= 1'b0;
            r_pwm       <= 1'b0;
            r_done      <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_duty <= 1'b0;
        end else begin
            r_per  <= w_per_next;
            r_duty <= w_duty_next;
            r_cnt  <= w_cnt_next;
            r_dir  <= w_dir_next;
            r_pwm  <= (w_state_next == S_RUN) && (w_cnt_next < w_duty_next);

            if (w_wrap) begin
                r_done <= 1'b1;
            end else if (w_wr_stat && WD[STAT_DONE]) begin
                r_done <= 1'b0;
            end

            // A shadow write on the wrap edge lands after the load and stays pending.
            if (!w_run) begin
                r_pend      <= 1'b0;
                r_pend_duty <= 1'b0;
            end else begin
                if (w_wrap) begin
                    r_pend      <= 1'b0;
                    r_pend_duty <= 1'b0;
                end
                if (w_wr_per || w_wr_duty) begin
                    r_pend <= 1'b1;
                end
                if (w_wr_duty) begin
                    r_pend_duty <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        RD = '0;
        case (A)
            ADDR_CTRL: begin
                RD[CTRL_EN]                      = (r_state == S_RUN);
                RD[CTRL_FADE]                    = r_fade;
                RD[CTRL_IE]                      = r_ie;
                RD[CTRL_PRESC_LSB +: PRESC_W]    = r_presc;
                RD[CTRL_STEP_LSB +: STEP_W]      = r_step;
            end
            ADDR_PERIOD: RD = 32'(r_per_sh);
            ADDR_DUTY:   RD = 32'(r_duty_sh);
            default:     RD = pack_status(r_done, r_pend, r_dir, 16'(r_cnt));
        endcase
    end

    assign PWM = r_pwm;
    assign IRQ = r_done && r_ie;

endmodule

// File: tb/tb_pwm_ctrl.sv
// Bench for pwm_ctrl: directed waveform scenarios with literal expectations plus
// a randomized register-traffic run, all checked against a phase-based model.
module tb_pwm_ctrl;

    logic        clk;
    logic        rst;
    logic [1:0]  A;
    logic [31:0] WD;
    logic        WE;
    logic [31:0] RD;
    logic        PWM;
    logic        IRQ;

    int n_checks;
    int n_errors;

    pwm_ctrl #(.CW(16)) dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .WD  (WD),
        .WE  (WE),
        .RD  (RD),
        .PWM (PWM),
        .IRQ (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: position in the period is a plain clock count since the period began.
    bit m_en, m_fade, m_ie, m_done, m_pend, m_pend_duty, m_dir, m_pwm;
    int m_presc, m_step, m_per_sh, m_duty_sh, m_per, m_duty, m_ph;

    function void model_reset();
        m_en = 0; m_fade = 0; m_ie = 0; m_done = 0; m_pend = 0;
        m_pend_duty = 0; m_dir = 0; m_pwm = 0;
        m_presc = 0; m_step = 0; m_per_sh = 0; m_duty_sh = 0;
        m_per = 0; m_duty = 0; m_ph = 0;
    endfunction

    function int model_cnt();
        return m_ph / (m_presc + 1);
    endfunction

    function void model_step();
        bit next_en, run, wrap;
        int len;
        if (rst) begin
            model_reset();
            return;
        end
        next_en = (WE && A == 2'd0) ? WD[0] : m_en;
        run     = m_en && next_en;
        len     = (m_per + 1) * (m_presc + 1);
        wrap    = run && (m_ph == len - 1);
        if (!run) begin
            m_ph = 0; m_per = m_per_sh; m_duty = m_duty_sh;
            m_pend = 0; m_pend_duty = 0;
        end else if (wrap) begin
            m_ph  = 0;
            m_per = m_per_sh;
            if (m_fade && !m_pend_duty) begin
                if (!m_dir) begin
                    if (m_duty + m_step >= m_per) begin m_duty = m_per; m_dir = 1; end
                    else m_duty = m_duty + m_step;
                end else begin
                    if (m_duty <= m_step) begin m_duty = 0; m_dir = 0; end
                    else m_duty = m_duty - m_step;
                end
            end else begin
                m_duty = m_duty_sh;
            end
            m_pend = 0; m_pend_duty = 0; m_done = 1;
        end else begin
            m_ph++;
        end
        if (WE) begin
            case (A)
                2'd0: begin
                    m_en = WD[0]; m_fade = WD[1]; m_ie = WD[2];
                    m_presc = int'(WD[15:8]); m_step = int'(WD[23:16]);
                end
                2'd1: begin m_per_sh = int'(WD[15:0]); if (run) m_pend = 1; end
                2'd2: begin
                    m_duty_sh = int'(WD[15:0]);
                    if (run) begin m_pend = 1; m_pend_duty = 1; end
                end
                default: if (WD[0] && !wrap) m_done = 0;
            endcase
        end
        m_pwm = next_en && (model_cnt() < m_duty);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            2'd0: begin
                r[0] = m_en; r[1] = m_fade; r[2] = m_ie;
                r[15:8] = 8'(m_presc); r[23:16] = 8'(m_step);
            end
            2'd1: r = 32'(m_per_sh);
            2'd2: r = 32'(m_duty_sh);
            default: begin
                r[0] = m_done; r[1] = m_pend; r[2] = m_dir;
                r[31:16] = 16'(model_cnt());
            end
        endcase
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive, let the edge happen, advance the model, compare everything.
    task automatic cycle(input logic [1:0] a, input logic [31:0] wd, input logic we);
        A = a; WD = wd; WE = we;
        if (we) $display("wr A=%0d WD=%08h", a, wd);
        @(posedge clk);
        model_step();
        #1;
        WE = 1'b0;
        chk("pwm", 32'(PWM), 32'(m_pwm));
        chk("irq", 32'(IRQ), 32'(m_done && m_ie));
        chk("rd", RD, exp_rd(A));
    endtask

    logic [31:0] pat;
    logic [31:0] aux;
    int          hi [6];

    initial begin
        n_checks = 0; n_errors = 0;
        A = 2'd0; WD = '0; WE = 1'b0; rst = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pwm", 32'(PWM), 32'd0);
        chk("rst_irq", 32'(IRQ), 32'd0);
        chk("rst_ctrl", RD, 32'd0);
        rst = 1'b0;

        // PERIOD=4 DUTY=2 PRESC=0: 2 high, 3 low, DONE after 5 clocks.
        cycle(2'd1, 32'd4, 1'b1);
        cycle(2'd2, 32'd2, 1'b1);
        cycle(2'd0, 32'h1, 1'b1);
        pat = 32'(PWM); aux = '0;
        for (int i = 1; i < 10; i++) begin
            cycle(2'd3, 32'd0, 1'b0);
            pat = {pat[30:0], PWM};
            aux = {aux[30:0], RD[0]};
        end
        chk("basic_wave", pat & 32'h3FF, 32'b1100011000);
        chk("basic_done", aux & 32'h1FF, 32'b000011111);

        // PRESC=3 PERIOD=1 DUTY=1: 4 high, 4 low, CNT steps every 4 clocks.
        cycle(2'd0, 32'h0, 1'b1);
        cycle(2'd1, 32'd1, 1'b1);
        cycle(2'd2, 32'd1, 1'b1);
        cycle(2'd0, 32'h301, 1'b1);
        pat = 32'(PWM); aux = '0;
        for (int i = 1; i < 16; i++) begin
            cycle(2'd3, 32'd0, 1'b0);
            pat = {pat[30:0], PWM};
            if (i < 8) aux = {aux[30:0], RD[16]};
        end
        chk("presc_wave", pat & 32'hFFFF, 32'b1111000011110000);
        chk("presc_cnt", aux & 32'h7F, 32'b0001111);

        // DUTY write mid-period stays pending until the wrap.
        cycle(2'd0, 32'h0, 1'b1);
        cycle(2'd1, 32'd4, 1'b1);
        cycle(2'd2, 32'd2, 1'b1);
        cycle(2'd0, 32'h1, 1'b1);
        pat = 32'(PWM); aux = '0;
        cycle(2'd3, 32'd0, 1'b0);
        pat = {pat[30:0], PWM};
        cycle(2'd2, 32'd4, 1'b1);
        pat = {pat[30:0], PWM};
        for (int i = 3; i < 10; i++) begin
            cycle(2'd3, 32'd0, 1'b0);
            pat = {pat[30:0], PWM};
            aux = {aux[30:0], RD[1]};
        end
        chk("shadow_wave", pat & 32'h3FF, 32'b1100011110);
        chk("shadow_pend", aux & 32'h7F, 32'b1100000);

        // FADE STEP=2 PERIOD=4 from DUTY=0: duties 0,2,4,2,0,2.
        cycle(2'd0, 32'h0, 1'b1);
        cycle(2'd1, 32'd4, 1'b1);
        cycle(2'd2, 32'd0, 1'b1);
        cycle(2'd0, 32'h0002_0003, 1'b1);
        for (int w = 0; w < 6; w++) hi[w] = 0;
        hi[0] = int'(PWM);
        aux = '0;
        for (int i = 1; i < 30; i++) begin
            cycle(2'd3, 32'd0, 1'b0);
            hi[i / 5] += int'(PWM);
            if (i == 10 || i == 15 || i == 20) aux = {aux[30:0], RD[2]};
        end
        chk("fade_p0", 32'(hi[0]), 32'd0);
        chk("fade_p1", 32'(hi[1]), 32'd2);
        chk("fade_p2", 32'(hi[2]), 32'd4);
        chk("fade_p3", 32'(hi[3]), 32'd2);
        chk("fade_p4", 32'(hi[4]), 32'd0);
        chk("fade_p5", 32'(hi[5]), 32'd2);
        chk("fade_dir", aux & 32'h7, 32'b110);

        // DONE clear on the wrap edge loses to the set; a later clear drops IRQ.
        cycle(2'd0, 32'h0, 1'b1);
        cycle(2'd1, 32'd4, 1'b1);
        cycle(2'd2, 32'd2, 1'b1);
        cycle(2'd3, 32'd1, 1'b1);
        cycle(2'd0, 32'h5, 1'b1);
        repeat (4) cycle(2'd3, 32'd0, 1'b0);
        chk("irq_before", 32'(IRQ), 32'd0);
        cycle(2'd3, 32'd1, 1'b1);
        chk("irq_wrapclr", 32'(IRQ), 32'd1);
        chk("done_wrapclr", 32'(RD[0]), 32'd1);
        cycle(2'd3, 32'd1, 1'b1);
        chk("irq_clr", 32'(IRQ), 32'd0);
        repeat (4) cycle(2'd3, 32'd0, 1'b0);
        chk("irq_again", 32'(IRQ), 32'd1);
        chk("pwm_before_rst", 32'(PWM), 32'd1);

        // Asynchronous reset mid-period, observed without a clock edge.
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_pwm", 32'(PWM), 32'd0);
        chk("arst_irq", 32'(IRQ), 32'd0);
        for (int a = 0; a < 4; a++) begin
            A = 2'(a);
            #0.5;
            chk("arst_rd", RD, 32'd0);
        end
        repeat (2) cycle(2'd3, 32'd0, 1'b0);
        rst = 1'b0;

        // Randomized register traffic; PRESC only changes while not running.
        for (int n = 0; n < 3000; n++) begin
            int          r;
            logic [31:0] wd;
            bit          en;
            r  = $urandom_range(0, 99);
            wd = $urandom;
            if (r < 60) begin
                cycle(2'($urandom_range(0, 3)), wd, 1'b0);
            end else if (r < 72) begin
                wd[15:0] = 16'($urandom_range(0, 6));
                cycle(2'd1, wd, 1'b1);
            end else if (r < 84) begin
                wd[15:0] = 16'($urandom_range(0, 8));
                cycle(2'd2, wd, 1'b1);
            end else if (r < 92) begin
                cycle(2'd3, wd, 1'b1);
            end else begin
                en        = ($urandom_range(0, 3) != 0);
                wd[0]     = en;
                wd[15:8]  = (m_en && en) ? 8'(m_presc) : 8'($urandom_range(0, 3));
                wd[23:16] = 8'($urandom_range(0, 3));
                cycle(2'd0, wd, 1'b1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
